pixel_compositor: RTL and testbench

Final pixel stage of the Space Invaders video path. It consumes per-layer on-flags and RGB from the sprite/background drawers (background, enemies, shots, player). It delays the VGA timing signals to match the drawers' RAM read latency and selects the highest-priority visible layer. It also applies a frame-synchronous hit-flash effect and drives registered VGA outputs.

---
 rtl/invaders_pkg.sv | 30 +++
 rtl/sync_delay.sv | 28 ++
 rtl/pixel_compositor.sv | 139 +++++++++++++
 tb/tb_pixel_compositor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared types for the Space Invaders video path.
// Layer indices, colour struct and hit-flash FSM states.
package invaders_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int LAYER_BG     = 0;
    localparam int LAYER_ENEMY  = 1;
    localparam int LAYER_SHOT   = 2;
    localparam int LAYER_PLAYER = 3;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FLASH
    } flash_state_t;

    function automatic rgb_t rgb_half(input rgb_t c);
        rgb_t h;
        h.r = {1'b0, c.r[7:1]};
        h.g = {1'b0, c.g[7:1]};
        h.b = {1'b0, c.b[7:1]};
        return h;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Enabled shift register with a parameterised reset value.
// Output is the last stage of a DEPTH-deep chain.
module sync_delay #(
    parameter int                 WIDTH   = 4,
    parameter int                 DEPTH   = 2,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// Final pixel stage: layer priority select, hit flash, registered VGA.
// Optional scanline dimming when COMPOSITOR_SCANLINE_EN is defined.
module pixel_compositor
    import invaders_pkg::*;
#(
    parameter int          N_LAYERS     = 4,
    parameter int          PIPE_DELAY   = 2,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [23:0] BG_COLOR     = 24'h000000
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  pixel_ce,
    input  logic [9:0]            DrawY,
    input  logic                  hs_in,
    input  logic                  vs_in,
    input  logic                  de_in,
    input  logic [N_LAYERS-1:0]   layer_on,
    input  logic [24*N_LAYERS-1:0] layer_rgb,
    input  logic                  hit_pulse,
    output logic [7:0]            VGA_R,
    output logic [7:0]            VGA_G,
    output logic [7:0]            VGA_B,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic                  VGA_BLANK_N,
    output logic                  flash_active
);

    localparam logic [7:0] CNT_LOAD = 8'(FLASH_FRAMES - 1);

    logic [3:0]   dly_out;
    logic         y0_d, de_d, hs_d, vs_d;
    rgb_t         sel, dim, pix_d, pix_q;
    logic         hs_q, vs_q, blank_n_q;
    logic         vs_prev_q, frame_edge, invert;
    flash_state_t state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;

    // Reset fills the line with idle syncs and blanking.
    sync_delay #(
        .WIDTH  (4),
        .DEPTH  (PIPE_DELAY),
        .RST_VAL(4'b0011)
    ) u_sync_delay (
        .clk  (Clk),
        .rst_n(Reset_n),
        .en_i (pixel_ce),
        .d_i  ({DrawY[0], de_in, hs_in, vs_in}),
        .q_o  (dly_out)
    );

    assign {y0_d, de_d, hs_d, vs_d} = dly_out;

    always_comb begin
        sel = rgb_t'(BG_COLOR);
        for (int i = 0; i < N_LAYERS; i++) begin
            if (layer_on[i]) sel = rgb_t'(layer_rgb[24*i +: 24]);
        end
        if (!de_d) sel = '0;
    end

`ifdef COMPOSITOR_SCANLINE_EN
    assign dim = (de_d && y0_d) ? rgb_half(sel) : sel;
`else
    assign dim = sel;
    logic unused_ok;
    assign unused_ok = ^{DrawY[9:1], y0_d};
`endif

    assign invert = (state_q == FLASH) && !cnt_q[0] && de_d;
    assign pix_d  = invert ? rgb_t'(~dim) : dim;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            vs_prev_q <= 1'b1;
        end else if (pixel_ce) begin
            pix_q     <= pix_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= de_d;
            vs_prev_q <= vs_in;
        end
    end

    assign frame_edge = pixel_ce && vs_prev_q && !vs_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (hit_pulse) state_d = ARMED;
            end
            ARMED: begin
                if (frame_edge) begin
                    state_d = FLASH;
                    cnt_d   = CNT_LOAD;
                end
            end
            FLASH: begin
                // A new hit restarts the flash even on a frame edge.
                if (hit_pulse) begin
                    cnt_d = CNT_LOAD;
                end else if (frame_edge) begin
                    if (cnt_q == 8'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign VGA_R        = pix_q.r;
    assign VGA_G        = pix_q.g;
    assign VGA_B        = pix_q.b;
    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_BLANK_N  = blank_n_q;
    assign flash_active = (state_q == FLASH);

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor (PIPE_DELAY=2, FLASH_FRAMES=4).
// Scanline vectors run only when COMPOSITOR_SCANLINE_EN is defined.
module tb_pixel_compositor;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pce;
    logic [9:0]  dy;
    logic        hs, vs, de, hit;
    logic [3:0]  lon;
    logic [95:0] lrgb;
    logic [7:0]  r, g, b;
    logic        ohs, ovs, oblank, flash;

    int n_chk = 0;
    int n_bad = 0;

    always #10 Clk = ~Clk;

    pixel_compositor #(
        .N_LAYERS    (4),
        .PIPE_DELAY  (2),
        .FLASH_FRAMES(4),
        .BG_COLOR    (24'h101010)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .pixel_ce    (pce),
        .DrawY       (dy),
        .hs_in       (hs),
        .vs_in       (vs),
        .de_in       (de),
        .layer_on    (lon),
        .layer_rgb   (lrgb),
        .hit_pulse   (hit),
        .VGA_R       (r),
        .VGA_G       (g),
        .VGA_B       (b),
        .VGA_HS      (ohs),
        .VGA_VS      (ovs),
        .VGA_BLANK_N (oblank),
        .flash_active(flash)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        pce = 1'b1;
        @(negedge Clk);
        pce = 1'b0;
        @(negedge Clk);
    endtask

    task automatic frame();
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
    endtask

    task automatic hit_on_edge();
        vs  = 1'b0;
        hit = 1'b1;
        pce = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
        pce = 1'b0;
        @(negedge Clk);
        vs  = 1'b1;
        tick();
    endtask

    task automatic set_layer(input int i, input logic [23:0] c);
        lrgb[24*i +: 24] = c;
    endtask

    function automatic logic [23:0] rgb();
        return {r, g, b};
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_rgb"},   32'(rgb()),  32'h0);
        check({tag, "_hs"},    32'(ohs),    32'h1);
        check({tag, "_vs"},    32'(ovs),    32'h1);
        check({tag, "_blank"}, 32'(oblank), 32'h0);
        check({tag, "_flash"}, 32'(flash),  32'h0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        Reset_n = 1'b0;
        pce = 1'b0; dy = '0; hs = 1'b1; vs = 1'b1; de = 1'b1;
        hit = 1'b0; lon = '0; lrgb = '0;
        repeat (3) @(negedge Clk);
        check_reset("por");
        Reset_n = 1'b1;
        @(negedge Clk);
        repeat (3) tick();

        set_layer(0, 24'hFF0000);
        set_layer(1, 24'h00FF00);
        lon = 4'b0011; tick();
        check("prio_0011", 32'(rgb()), 32'h00FF00);
        lon = 4'b0001; tick();
        check("prio_0001", 32'(rgb()), 32'hFF0000);
        lon = 4'b0000; tick();
        check("prio_bg", 32'(rgb()), 32'h101010);
        set_layer(3, 24'hABCDEF);
        lon = 4'b1000; tick();
        check("prio_1000", 32'(rgb()), 32'hABCDEF);
        de = 1'b0;
        repeat (3) tick();
        check("blank_rgb", 32'(rgb()), 32'h0);
        check("blank_n", 32'(oblank), 32'h0);

        lon = '0;
        tick(); tick();
        de = 1'b1; hs = 1'b0; tick();
        check("al_k_blank", 32'(oblank), 32'h0);
        check("al_k_hs", 32'(ohs), 32'h1);
        de = 1'b0; hs = 1'b1; tick();
        check("al_k1_blank", 32'(oblank), 32'h0);
        set_layer(2, 24'h112233);
        lon = 4'b0100; tick();
        check("al_k2_blank", 32'(oblank), 32'h1);
        check("al_k2_hs", 32'(ohs), 32'h0);
        check("al_k2_rgb", 32'(rgb()), 32'h112233);
        lon = '0; tick();
        check("al_k3_blank", 32'(oblank), 32'h0);
        check("al_k3_hs", 32'(ohs), 32'h1);
        check("al_k3_rgb", 32'(rgb()), 32'h0);

        de = 1'b1; lrgb = '0;
        set_layer(0, 24'h123456);
        lon = 4'b0001;
        repeat (3) tick();
        check("fl_pre", 32'(rgb()), 32'h123456);
        pulse_hit();
        check("fl_armed", 32'(flash), 32'h0);
        pulse_hit();
        check("fl_armed_hit", 32'(flash), 32'h0);
        frame();
        check("fl_e1_act", 32'(flash), 32'h1);
        check("fl_e1_rgb", 32'(rgb()), 32'h123456);
        frame();
        check("fl_e2_rgb", 32'(rgb()), 32'hEDCBA9);
        frame();
        check("fl_e3_rgb", 32'(rgb()), 32'h123456);
        frame();
        check("fl_e4_rgb", 32'(rgb()), 32'hEDCBA9);
        check("fl_e4_act", 32'(flash), 32'h1);
        frame();
        check("fl_e5_act", 32'(flash), 32'h0);
        check("fl_e5_rgb", 32'(rgb()), 32'h123456);

        hit_on_edge();
        check("idle_hit_edge", 32'(flash), 32'h0);
        frame();
        check("idle_next_act", 32'(flash), 32'h1);
        frame(); frame();
        check("cnt1_rgb", 32'(rgb()), 32'h123456);
        hit_on_edge();
        check("reload_rgb", 32'(rgb()), 32'h123456);
        check("reload_act", 32'(flash), 32'h1);
        frame();
        check("reload_e1_rgb", 32'(rgb()), 32'hEDCBA9);

        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset("mid");
        Reset_n = 1'b1;
        @(negedge Clk);
        repeat (3) tick();
        check("post_rst_rgb", 32'(rgb()), 32'h123456);
        check("post_rst_act", 32'(flash), 32'h0);
        frame();
        check("post_rst_frame", 32'(rgb()), 32'h123456);

`ifdef COMPOSITOR_SCANLINE_EN
        dy = 10'd1;
        set_layer(0, 24'h80FF40);
        repeat (3) tick();
        check("scan_dim", 32'(rgb()), 32'h407F20);
        pulse_hit();
        frame(); frame();
        check("scan_flash", 32'(rgb()), 32'hBF80DF);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
